// File: rtl/pulse_width_encoder_pkg.sv
// pulse_width_encoder_pkg: shared FSM state type and pipeline/pulse-width constants.
package pulse_width_encoder_pkg;
    typedef enum logic {IDLE, STREAM} state_t;
    localparam int PIPE_LAT = 3;
    localparam int PW_MAX = 256;
    localparam int PW_W = 9;
endpackage

// File: rtl/pwe_table.sv
// pwe_table: read-first memory, one write port and one registered read port, BRAM-inferable.
module pwe_table #(
    parameter int AW = 8,
    parameter int DW = 9
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [2**AW];
    // Write and registered read share the edge; a colliding read sees the old contents.
    always_ff @(posedge CLK) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/pulse_width_encoder.sv
// pulse_width_encoder: intensity -> pulse width via lookup table, 3-stage pipeline with frame indexing.
// Optional output clamp to 256 with OVERRANGE flag: `define PULSE_WIDTH_ENCODER_CLAMP_EN.
module pulse_width_encoder
    import pulse_width_encoder_pkg::*;
#(
    parameter int DEPTH = 249,
    parameter int TABLE_AW = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     DIN_VALID,
    input  logic [15:0]              INTENSITY_IN,
    input  logic [7:0]               PHASE_IN,
    input  logic                     TBL_WE,
    input  logic [TABLE_AW-1:0]      TBL_ADDR,
    input  logic [PW_W-1:0]          TBL_DATA,
    output logic [PW_W-1:0]          PULSE_WIDTH_OUT,
    output logic [7:0]               PHASE_OUT,
    output logic [$clog2(DEPTH)-1:0] IDX_OUT,
    output logic                     DOUT_VALID,
    output logic                     UNDERRUN,
    output logic                     OVERRANGE
);
    localparam int IW = $clog2(DEPTH);

    state_t                state, state_nxt;
    logic [IW-1:0]         cnt, cnt_nxt, item_idx;
    logic                  last, short_frame;
    logic                  s1_valid, s2_valid;
    logic [TABLE_AW-1:0]   s1_addr;
    logic [7:0]            s1_phase, s2_phase;
    logic [IW-1:0]         s1_idx, s2_idx;
    logic [PW_W-1:0]       tbl_q, pw_enc;
    logic                  unused_lsbs;

    assign unused_lsbs = ^INTENSITY_IN;

    // Frame tracking state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Index of the incoming item; a valid item either continues the frame or closes it on DEPTH-1.
    always_comb begin
        item_idx = (state == STREAM) ? cnt : '0;
        last = item_idx == IW'(DEPTH - 1);
        state_nxt = (DIN_VALID && !last) ? STREAM : IDLE;
        cnt_nxt = (DIN_VALID && !last) ? item_idx + IW'(1) : '0;
        short_frame = !DIN_VALID && (state == STREAM);
    end

    // Stages 1 and 2: capture input, then carry phase/index alongside the table read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_addr <= '0;
            s1_phase <= '0;
            s1_idx <= '0;
            s2_valid <= 1'b0;
            s2_phase <= '0;
            s2_idx <= '0;
        end else begin
            s1_valid <= DIN_VALID;
            s1_addr <= INTENSITY_IN[15 -: TABLE_AW];
            s1_phase <= PHASE_IN;
            s1_idx <= item_idx;
            s2_valid <= s1_valid;
            s2_phase <= s1_phase;
            s2_idx <= s1_idx;
        end
    end

    pwe_table #(.AW(TABLE_AW), .DW(PW_W)) u_table (
        .CLK     (CLK),
        .we      (TBL_WE),
        .wr_addr (TBL_ADDR),
        .wr_data (TBL_DATA),
        .rd_addr (s1_addr),
        .rd_data (tbl_q)
    );

`ifdef PULSE_WIDTH_ENCODER_CLAMP_EN
    logic over;
    // Saturate table values above the nominal maximum.
    always_comb begin
        over = tbl_q > PW_W'(PW_MAX);
        pw_enc = over ? PW_W'(PW_MAX) : tbl_q;
    end

    // Sticky overrange flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) OVERRANGE <= 1'b0;
        else OVERRANGE <= OVERRANGE | (s2_valid & over);
    end
`else
    assign pw_enc = tbl_q;
    assign OVERRANGE = 1'b0;
`endif

    // Stage 3: output register, holding the last item while no new one arrives.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DOUT_VALID <= 1'b0;
            PULSE_WIDTH_OUT <= '0;
            PHASE_OUT <= '0;
            IDX_OUT <= '0;
            UNDERRUN <= 1'b0;
        end else begin
            DOUT_VALID <= s2_valid;
            UNDERRUN <= UNDERRUN | short_frame;
            if (s2_valid) begin
                PULSE_WIDTH_OUT <= pw_enc;
                PHASE_OUT <= s2_phase;
                IDX_OUT <= s2_idx;
            end
        end
    end
endmodule

// File: tb/tb_pulse_width_encoder.sv
// tb_pulse_width_encoder: directed self-checking bench for pulse_width_encoder.
module tb_pulse_width_encoder;
    import pulse_width_encoder_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       DIN_VALID;
    logic [15:0] INTENSITY_IN;
    logic [7:0] PHASE_IN;
    logic       TBL_WE;
    logic [7:0] TBL_ADDR;
    logic [8:0] TBL_DATA;
    logic [8:0] PULSE_WIDTH_OUT;
    logic [7:0] PHASE_OUT;
    logic [7:0] IDX_OUT;
    logic       DOUT_VALID;
    logic       UNDERRUN;
    logic       OVERRANGE;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_in;
    int q_pw[$], q_ph[$], q_idx[$], q_cyc[$];

    pulse_width_encoder dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .DIN_VALID       (DIN_VALID),
        .INTENSITY_IN    (INTENSITY_IN),
        .PHASE_IN        (PHASE_IN),
        .TBL_WE          (TBL_WE),
        .TBL_ADDR        (TBL_ADDR),
        .TBL_DATA        (TBL_DATA),
        .PULSE_WIDTH_OUT (PULSE_WIDTH_OUT),
        .PHASE_OUT       (PHASE_OUT),
        .IDX_OUT         (IDX_OUT),
        .DOUT_VALID      (DOUT_VALID),
        .UNDERRUN        (UNDERRUN),
        .OVERRANGE       (OVERRANGE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every valid output item on the falling edge.
    always @(negedge CLK) begin
        if (DOUT_VALID) begin
            q_pw.push_back(int'(PULSE_WIDTH_OUT));
            q_ph.push_back(int'(PHASE_OUT));
            q_idx.push_back(int'(IDX_OUT));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_q();
        q_pw.delete();
        q_ph.delete();
        q_idx.delete();
        q_cyc.delete();
    endtask

    task automatic set_item(input int k);
        DIN_VALID = 1'b1;
        INTENSITY_IN = {8'(k), 8'hA5};
        PHASE_IN = 8'(255 - k);
    endtask

    task automatic drive_items(input int n);
        for (int i = 0; i < n; i++) begin
            set_item(i % 249);
            tick();
        end
        DIN_VALID = 1'b0;
    endtask

    task automatic tbl_write(input int a, input int d);
        TBL_WE = 1'b1;
        TBL_ADDR = 8'(a);
        TBL_DATA = 9'(d);
        tick();
        TBL_WE = 1'b0;
    endtask

    task automatic drain();
        repeat (PIPE_LAT + 3) tick();
    endtask

    // Output i of a stream of consecutive frames must be item i%249 with table[a]=a.
    task automatic check_items(input string tag, input int n);
        check({tag, "_count"}, q_pw.size(), n);
        for (int i = 0; i < q_pw.size() && i < n; i++) begin
            int k;
            k = i % 249;
            check($sformatf("%s_item%0d", tag, i),
                  (q_pw[i] << 16) | (q_ph[i] << 8) | q_idx[i],
                  (k << 16) | ((255 - k) << 8) | k);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        DIN_VALID = 1'b0;
        INTENSITY_IN = '0;
        PHASE_IN = '0;
        TBL_WE = 1'b0;
        TBL_ADDR = '0;
        TBL_DATA = '0;
        repeat (3) tick();
        check("rst_valid", DOUT_VALID, 0);
        check("rst_pw", PULSE_WIDTH_OUT, 0);
        check("rst_phase", PHASE_OUT, 0);
        check("rst_idx", IDX_OUT, 0);
        check("rst_underrun", UNDERRUN, 0);
        check("rst_overrange", OVERRANGE, 0);
        RST_N = 1'b1;
        tick();
        for (int a = 0; a < 256; a++) tbl_write(a, a);
        drain();

        // Single full frame, latency 3 from first input.
        clear_q();
        first_in = cyc;
        drive_items(249);
        drain();
        check_items("t1", 249);
        if (q_cyc.size() > 0) check("t1_latency", q_cyc[0] - first_in, 3);
        check("t1_underrun", UNDERRUN, 0);

        // Two back-to-back frames with no bubble.
        clear_q();
        drive_items(498);
        drain();
        check_items("t2", 498);
        if (q_cyc.size() == 498) check("t2_consecutive", q_cyc[497] - q_cyc[0], 497);
        check("t2_underrun", UNDERRUN, 0);

        // Short frame, then a fresh full frame.
        clear_q();
        drive_items(100);
        drain();
        check_items("t3a", 100);
        check("t3_underrun", UNDERRUN, 1);
        clear_q();
        drive_items(249);
        drain();
        check_items("t3b", 249);

        // Out-of-range table entry.
        tbl_write(16, 300);
        clear_q();
        DIN_VALID = 1'b1;
        INTENSITY_IN = 16'h1000;
        PHASE_IN = 8'h3C;
        tick();
        DIN_VALID = 1'b0;
        drain();
        check("t4_count", q_pw.size(), 1);
`ifdef PULSE_WIDTH_ENCODER_CLAMP_EN
        check("t4_pw", PULSE_WIDTH_OUT, 256);
        check("t4_overrange", OVERRANGE, 1);
`else
        check("t4_pw", PULSE_WIDTH_OUT, 300);
        check("t4_overrange", OVERRANGE, 0);
`endif
        check("t4_phase", PHASE_OUT, 8'h3C);
        tbl_write(16, 16);

        // Write colliding with a table read returns old data, next read sees new data.
        clear_q();
        DIN_VALID = 1'b1;
        INTENSITY_IN = 16'h0500;
        PHASE_IN = 8'hA1;
        tick();
        TBL_WE = 1'b1;
        TBL_ADDR = 8'd5;
        TBL_DATA = 9'd7;
        PHASE_IN = 8'hA2;
        tick();
        TBL_WE = 1'b0;
        DIN_VALID = 1'b0;
        drain();
        check("t5_count", q_pw.size(), 2);
        if (q_pw.size() == 2) begin
            check("t5_old", q_pw[0], 5);
            check("t5_new", q_pw[1], 7);
            check("t5_idx", q_idx[1], 1);
        end
        tbl_write(5, 5);

        // Asynchronous reset mid-frame.
        clear_q();
        for (int i = 0; i <= 120; i++) begin
            set_item(i);
            tick();
        end
        check("t6_pre_valid", DOUT_VALID, 1);
        #2;
        RST_N = 1'b0;
        DIN_VALID = 1'b0;
        #1;
        check("t6_async_valid", DOUT_VALID, 0);
        check("t6_async_pw", PULSE_WIDTH_OUT, 0);
        check("t6_async_phase", PHASE_OUT, 0);
        check("t6_async_idx", IDX_OUT, 0);
        check("t6_async_underrun", UNDERRUN, 0);
        clear_q();
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (5) tick();
        check("t6_no_partial", q_pw.size(), 0);
        check("t6_underrun_idle", UNDERRUN, 0);
        drive_items(249);
        drain();
        check_items("t6", 249);
        check("t6_underrun", UNDERRUN, 0);
        check("t6_overrange", OVERRANGE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_width_encoder.md
PULSE_WIDTH_ENCODER -- requirements
Module: pulse_width_encoder

Interface
REQ-001 Parameter DEPTH, default 249: transducer items per frame.
REQ-002 Parameter TABLE_AW, default 8: table address width; 2^TABLE_AW entries.
REQ-003 CLK  in  1  sole clock; all logic on posedge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 DIN_VALID  in  1  one item per cycle when high (upstream interpolator output).
REQ-006 INTENSITY_IN  in  16  interpolated intensity.
REQ-007 PHASE_IN  in  8  interpolated phase.
REQ-008 TBL_WE  in  1  table write strobe.
REQ-009 TBL_ADDR  in  TABLE_AW  table write address.
REQ-010 TBL_DATA  in  9  table write data (pulse width).
REQ-011 PULSE_WIDTH_OUT  out  9  encoded pulse width, 0..256 nominal.
REQ-012 PHASE_OUT  out  8  phase, delayed to align with PULSE_WIDTH_OUT.
REQ-013 IDX_OUT  out  $clog2(DEPTH)  item index of current output.
REQ-014 DOUT_VALID  out  1  output item valid.
REQ-015 UNDERRUN  out  1  sticky: frame ended short.
REQ-016 OVERRANGE  out  1  sticky: table value > 256 seen (macro-dependent).

Function
REQ-017 Table: single-port-write, single-port-read memory, 2^TABLE_AW x 9; read address = INTENSITY_IN[15 -: TABLE_AW].
REQ-018 Same-cycle write and read of one address returns old data (read-first).
REQ-019 Fixed latency 3 cycles DIN_VALID -> DOUT_VALID: stage 1 register input, stage 2 table read, stage 3 clamp/output register.
REQ-020 PHASE_IN, index and valid are pipelined alongside intensity; no item is dropped or reordered.
REQ-021 FSM states IDLE, STREAM; IDLE -> STREAM on DIN_VALID high, index reset to 0 for that item.
REQ-022 In STREAM, index increments per valid item; after item DEPTH-1 accepted, -> IDLE.
REQ-023 DIN_VALID low in STREAM before item DEPTH-1: set UNDERRUN, -> IDLE; next DIN_VALID starts new frame at index 0.
REQ-024 DIN_VALID high in the cycle after item DEPTH-1: treated as index 0 of a new frame (back-to-back frames allowed, no bubble).
REQ-025 DOUT_VALID low: PULSE_WIDTH_OUT, PHASE_OUT, IDX_OUT hold last values.
REQ-026 Sticky flags clear only on reset.

Reset
REQ-027 RST_N low: all outputs 0, FSM IDLE, index 0, pipeline valids 0, flags 0; table contents unaffected.
REQ-028 Reset mid-frame aborts frame; no partial items emitted after release; UNDERRUN not set by reset.

Configuration
REQ-029 PULSE_WIDTH_ENCODER_CLAMP_EN defined: table values > 256 output as 256 and set OVERRANGE.
REQ-030 PULSE_WIDTH_ENCODER_CLAMP_EN undefined: table value passed unmodified; OVERRANGE tied 0.

Structure
REQ-031 Shared package holds state enum (IDLE, STREAM), pipeline latency constant (3), pulse-width max constant (256), pulse-width width (9).
REQ-032 One sub-module, pwe_table (parameterised read-first memory, inferable as BRAM).

Verification
REQ-033 Table[a]=a for all a; frame of 249 items INTENSITY_IN=k<<8 -> 249 outputs, PULSE_WIDTH_OUT=k, IDX 0..248, first valid 3 cycles after first DIN_VALID.
REQ-034 Two back-to-back 249-item frames -> DOUT_VALID high 498 consecutive cycles, IDX wraps 248->0, UNDERRUN=0.
REQ-035 DIN_VALID drops after 100 items -> UNDERRUN=1, 100 outputs; next frame starts IDX=0.
REQ-036 Table[0x10]=300, INTENSITY_IN=0x1000 -> with macro: 256, OVERRANGE=1; without: 300, OVERRANGE=0.
REQ-037 Write Table[5]=7 (old 5) same cycle as read of addr 5 -> output 5; next read -> 7.
REQ-038 RST_N low at item 120 -> outputs 0 asynchronously; after release, new 249-item frame emits IDX 0..248 correctly.
